// File: rtl/cache_pkg.sv
// Shared op encodings, issuer state type and op filter for the cache request queue.
package cache_pkg;

    localparam logic [7:0] OP_READ  = 8'h72;
    localparam logic [7:0] OP_WRITE = 8'h77;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } req_state_t;

    function automatic logic op_legal(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Circular FIFO with wrapping pointers, a separate occupancy count and a registered
// copy of the head entry, so readers see flop outputs only.
module req_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 40,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [OCC_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             wr, rd;

    assign full  = (count_q == OCC_W'(DEPTH));
    assign empty = (count_q == '0);
    assign wr    = push && !full && !flush;
    assign rd    = pop && !empty && !flush;
    assign rdata = rdata_q;
    assign count = count_q;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no latch is inferred.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rdata_d = rdata_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr) tail_d = tail_q + PTR_W'(1);
            if (rd) head_d = head_q + PTR_W'(1);
            if (wr && !rd)      count_d = count_q + OCC_W'(1);
            else if (rd && !wr) count_d = count_q - OCC_W'(1);
            // Head copy follows the next entry; when the queue runs dry it keeps the last popped value.
            if (rd && (count_q > OCC_W'(1)))
                rdata_d = mem_q[head_q + PTR_W'(1)];
            else if (wr && ((count_q == '0) || (rd && (count_q == OCC_W'(1)))))
                rdata_d = wdata;
        end
    end

    // NOTE: storage is deliberately not reset; only rdata_q is visible and it is reset.
    always_ff @(posedge clk) begin
        if (wr) mem_q[tail_q] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/cache_req_queue.sv
// Trace request buffer in front of cache_engine: filters illegal ops, queues entries,
// issues one per cycle and tracks end-of-trace with issue/drop statistics.
module cache_req_queue
    import cache_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int IN_ADDR_W  = 32,
    parameter int OUT_ADDR_W = 48,
    parameter int CNT_W      = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_ADDR_W-1:0]         in_addr,
    input  logic [7:0]                   in_op,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_ADDR_W-1:0]        out_addr,
    output logic [7:0]                   out_op,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_W-1:0]             issued_reads,
    output logic [CNT_W-1:0]             issued_writes,
    output logic [CNT_W-1:0]             dropped,
    output logic                         done
);

    localparam int ENT_W = IN_ADDR_W + 8;

    req_state_t             state_q, state_d;
    logic [CNT_W-1:0]       reads_q, reads_d, writes_q, writes_d, dropped_q, dropped_d;
    logic                   accept, legal, push, pop;
    logic [ENT_W-1:0]       head_ent;
    logic [IN_ADDR_W-1:0]   head_addr;

    assign legal  = op_legal(in_op);
    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_addr, in_op}),
        .rdata (head_ent),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head_addr = head_ent[ENT_W-1:8];
    assign out_op    = head_ent[7:0];
    assign out_addr  = OUT_ADDR_W'(head_addr);
    assign out_valid = !empty;
    // Gated by reset so the handshake stays quiet while reset is held.
    assign in_ready  = !reset && !full && ((state_q == IDLE) || (state_q == RUN));
    assign done      = (state_q == DONE);

    assign issued_reads  = reads_q;
    assign issued_writes = writes_q;
    assign dropped       = dropped_q;

    always_comb begin
        state_d   = state_q;
        reads_d   = reads_q;
        writes_d  = writes_q;
        dropped_d = dropped_q;
        if (!flush) begin
            if (pop && (out_op == OP_READ) && (reads_q != '1))   reads_d  = reads_q + CNT_W'(1);
            if (pop && (out_op == OP_WRITE) && (writes_q != '1)) writes_d = writes_q + CNT_W'(1);
            if (accept && !legal && (dropped_q != '1))           dropped_d = dropped_q + CNT_W'(1);
        end
        unique case (state_q)
            IDLE:  if (accept && !flush) state_d = in_last ? DRAIN : RUN;
            RUN:   if (accept && !flush && in_last) state_d = DRAIN;
            DRAIN: if (count == '0) state_d = DONE;
            DONE: begin
                if (start) begin
                    state_d   = IDLE;
                    reads_d   = '0;
                    writes_d  = '0;
                    dropped_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            reads_q   <= '0;
            writes_q  <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            reads_q   <= reads_d;
            writes_q  <= writes_d;
            dropped_q <= dropped_d;
        end
    end

endmodule

// File: tb/tb_cache_req_queue.sv
// Directed bench for cache_req_queue with a scoreboard of expected issued entries
// and independent models of the issue/drop counters.
module tb_cache_req_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_addr;
    logic [7:0]  in_op;
    logic        out_valid, out_ready;
    logic [47:0] out_addr;
    logic [7:0]  out_op;
    logic [3:0]  count;
    logic        full, empty;
    logic [11:0] issued_reads, issued_writes, dropped;
    logic        done;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  op;
    } ent_t;

    ent_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_reads = '0, exp_writes = '0, exp_dropped = '0;

    always #5 clk = ~clk;

    cache_req_queue #(
        .DEPTH(DEPTH), .IN_ADDR_W(32), .OUT_ADDR_W(48), .CNT_W(12)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_op(in_op),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_op(out_op), .count(count), .full(full), .empty(empty),
        .issued_reads(issued_reads), .issued_writes(issued_writes), .dropped(dropped),
        .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] sat(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // Scoreboard side: a pop happens at the next rising edge when this holds.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                ent_t e;
                e = sb.pop_front();
                check("pop_entry", {out_addr, out_op}, {16'h0, 8'h0, e.addr, e.op} >> 8 << 8 | {16'h0, e.addr, e.op});
                if (e.op == 8'h72) exp_reads  = sat(exp_reads);
                else               exp_writes = sat(exp_writes);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [7:0] op, input logic last);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_addr  = a;
        in_op    = op;
        in_last  = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (op == 8'h72 || op == 8'h77) sb.push_back('{addr: a, op: op});
                else                            exp_dropped = sat(exp_dropped);
            end
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_empty();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            seen = empty;
        end
        check("drain_timeout", 64'(seen), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out"}, {out_addr, out_op}, 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_flags"}, {62'd0, full, empty}, 64'd1);
        check({tag, "_stats"}, {issued_reads, issued_writes, dropped}, 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_addr = '0; in_op = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        check_reset_outputs("rst");
        reset = 1'b0;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic order with the engine always ready.
        out_ready = 1'b1;
        send(32'h10, 8'h72, 1'b0);
        check("latency_valid", {out_valid, out_addr, out_op}, {1'b1, 48'h10, 8'h72});
        send(32'h20, 8'h77, 1'b0);
        send(32'h30, 8'h72, 1'b0);
        wait_empty();
        check("basic_reads", 64'(issued_reads), 64'd2);
        check("basic_writes", 64'(issued_writes), 64'd1);
        check("basic_sb", 64'(sb.size()), 64'd0);

        // Fill and stall.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(32'h100 + 32'(i), (i % 2 == 0) ? 8'h72 : 8'h77, 1'b0);
        check("fill_full", {60'd0, full, in_ready, count[1:0]}, {60'd0, 1'b1, 1'b0, 2'd0});
        check("fill_count", 64'(count), 64'd8);
        in_valid = 1'b1; in_addr = 32'h108; in_op = 8'h72; in_last = 1'b0;
        sb.push_back('{addr: 32'h108, op: 8'h72});
        repeat (3) step();
        check("stall_count", 64'(count), 64'd8);
        check("stall_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("one_pop_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("refill_count", 64'(count), 64'd8);
        check("refill_full", 64'(full), 64'd1);
        out_ready = 1'b1;
        wait_empty();
        check("fill_reads", 64'(issued_reads), 64'(exp_reads));
        check("fill_writes", 64'(issued_writes), 64'(exp_writes));

        // Illegal ops are accepted and discarded.
        out_ready = 1'b0;
        send(32'h40, 8'h78, 1'b0);
        send(32'h42, 8'h00, 1'b0);
        send(32'h44, 8'h72, 1'b0);
        check("illegal_dropped", 64'(dropped), 64'd2);
        check("illegal_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        wait_empty();
        check("illegal_reads", 64'(issued_reads), 64'(exp_reads));

        // End of trace, drain and restart.
        out_ready = 1'b0;
        send(32'h50, 8'h72, 1'b0);
        send(32'h54, 8'h77, 1'b0);
        send(32'h58, 8'h72, 1'b1);
        check("drain_in_ready", 64'(in_ready), 64'd0);
        check("drain_count", 64'(count), 64'd3);
        out_ready = 1'b1;
        repeat (3) step();
        check("drain_last_pop", {count, done}, {4'd0, 1'b0});
        step();
        check("done_rise", 64'(done), 64'd1);
        step();
        check("done_hold", 64'(done), 64'd1);
        check("done_in_ready", 64'(in_ready), 64'd0);
        check("done_stats", {issued_reads, issued_writes, dropped}, {exp_reads, exp_writes, exp_dropped});
        start = 1'b1;
        step();
        start = 1'b0;
        exp_reads = '0; exp_writes = '0; exp_dropped = '0;
        check("start_stats", {issued_reads, issued_writes, dropped}, 64'd0);
        check("start_idle", {done, in_ready}, 64'd1);

        // Flush while pushing and popping with five entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h200 + 32'(i), (i == 2) ? 8'h77 : 8'h72, 1'b0);
        check("pre_flush_count", 64'(count), 64'd5);
        in_valid = 1'b1; in_addr = 32'h999; in_op = 8'h72; out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        check("flush_count", {count, empty}, {4'd0, 1'b1});
        check("flush_stats", {issued_reads, issued_writes, dropped}, {exp_reads, exp_writes, exp_dropped});
        in_valid = 1'b1; in_addr = 32'h998; in_op = 8'h55; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_no_drop", 64'(dropped), 64'(exp_dropped));
        send(32'h5, 8'h01, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored", 64'(dropped), 64'(exp_dropped));

        // Asynchronous reset in mid-stream.
        send(32'h300, 8'h72, 1'b0);
        send(32'h304, 8'h77, 1'b0);
        in_valid = 1'b1; in_addr = 32'h308; in_op = 8'h72;
        #1 reset = 1'b1;
        #1 check_reset_outputs("mid_rst");
        reset = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_reads = '0; exp_writes = '0; exp_dropped = '0;
        step();

        // Long stream: counter saturation and pointer wrap.
        out_ready = 1'b1;
        for (int i = 0; i < 4200; i++) send(32'h1000 + 32'(i) * 32'd4, 8'h72, 1'b0);
        wait_empty();
        check("sat_reads", 64'(issued_reads), 64'hFFF);
        check("sat_model", 64'(issued_reads), 64'(exp_reads));
        check("sat_writes", 64'(issued_writes), 64'd0);
        check("sat_sb", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
